// File: rtl/can_tx_bitstream.sv
// ---------------------------------------------------------------------------
// can_tx_bitstream
//   Bit-level CAN transmit engine. Pulls frame bits from the frame builder,
//   inserts stuff bits, drives the bus on tx_point and checks the bus at
//   sample_point for arbitration loss or bit errors.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   go_tx               start a frame (pulse, honoured in IDLE only)
//   go_error_frame      abort the frame and release the bus
//   tx_point            drive strobe (1 cycle per bit)
//   sample_point        sample strobe (1 cycle per bit)
//   sampled_bit         bus value at sample_point
//   in_valid/in_ready   upstream bit handshake (see below)
//   in_bit              bit value, 0 = dominant
//   in_stuff_en         bit lies in the stuffed region
//   in_arb              bit lies in the arbitration field
//   in_nocheck          bit is exempt from the bit-error check
//   in_last             final bit of the frame
//   tx                  registered bus drive bit
//   tx_next             bit that the next tx_point will drive
//   transmitting        engine is in TX or DRAIN
//   stuff_active        the bit on the bus is a stuff bit
//   arb_lost, bit_error, tx_done   one-cycle result pulses
//
// Optional feature (macro CAN_TX_STATS_EN): adds saturating counters
//   stuff_cnt, err_cnt, underrun_cnt of width CNT_W.
//
// Handshake: a bit transfers on a cycle where in_valid and in_ready are both
// high. in_ready is combinational and only rises on a tx_point in TX when no
// stuff bit is owed, so upstream holds in_valid/in_bit until it sees ready.
// ---------------------------------------------------------------------------
module can_tx_bitstream #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go_tx,
  input  logic             go_error_frame,
  input  logic             tx_point,
  input  logic             sample_point,
  input  logic             sampled_bit,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_stuff_en,
  input  logic             in_arb,
  input  logic             in_nocheck,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tx,
  output logic             tx_next,
  output logic             transmitting,
  output logic             stuff_active,
  output logic             arb_lost,
  output logic             bit_error,
  output logic             tx_done
`ifdef CAN_TX_STATS_EN
  ,
  output logic [CNT_W-1:0] stuff_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] underrun_cnt
`endif
);

  if (CNT_W < 1 || STUFF_LEN < 2 || STUFF_LEN > 7) begin : g_bad_params
    $error("can_tx_bitstream: CNT_W must be >= 1 and STUFF_LEN in 2..7");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TX    = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       tx_q, tx_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  logic       last_bit_q, last_bit_d;
  logic       stuff_pending_q, stuff_pending_d;
  logic       stuff_active_q, stuff_active_d;
  logic       cur_arb_q, cur_arb_d;
  logic       cur_nocheck_q, cur_nocheck_d;
  logic       arb_lost_q, arb_lost_d;
  logic       bit_error_q, bit_error_d;
  logic       tx_done_q, tx_done_d;

  logic       active;
  logic       drive_slot;
  logic       accept;
  logic       underrun;
  logic       check;
  logic       mismatch;
  logic       arb_det;
  logic       err_det;
  logic       done_det;
  logic [2:0] run_inc;

  // go_error_frame overrides any strobe arriving in the same cycle.
  assign active     = (state_q == S_TX) || (state_q == S_DRAIN);
  assign drive_slot = tx_point & active & ~go_error_frame;
  assign accept     = tx_point & (state_q == S_TX) & in_valid
                      & ~stuff_pending_q & ~go_error_frame;
  assign underrun   = drive_slot & (state_q == S_TX) & ~in_valid & ~stuff_pending_q;

  assign in_ready   = accept;
  assign tx_next    = stuff_pending_q ? ~last_bit_q
                    : ((state_q == S_TX) && in_valid) ? in_bit : 1'b1;

  // The check always compares against the registered tx, so a coincident
  // tx_point cannot disturb the bit that is being sampled.
  assign check    = sample_point & active & ~go_error_frame;
  assign mismatch = sampled_bit ^ tx_q;
  assign arb_det  = check & mismatch & cur_arb_q & ~stuff_active_q & tx_q & ~sampled_bit;
  assign err_det  = check & mismatch & ~arb_det & ~cur_nocheck_q;
  // A stuff bit still owed after the last frame bit holds off completion
  // until that stuff bit has itself been driven and sampled.
  assign done_det = check & (state_q == S_DRAIN) & ~stuff_pending_q & ~arb_det & ~err_det;

  assign run_inc  = (in_bit == last_bit_q) ? run_cnt_q + 3'd1 : 3'd1;

  always_comb begin
    state_d         = state_q;
    tx_d            = tx_q;
    run_cnt_d       = run_cnt_q;
    last_bit_d      = last_bit_q;
    stuff_pending_d = stuff_pending_q;
    stuff_active_d  = stuff_active_q;
    cur_arb_d       = cur_arb_q;
    cur_nocheck_d   = cur_nocheck_q;
    arb_lost_d      = arb_det;
    bit_error_d     = err_det;
    tx_done_d       = done_det;

    case (state_q)
      S_IDLE: begin
        if (go_tx) begin
          state_d         = S_TX;
          run_cnt_d       = 3'd0;
          last_bit_d      = 1'b1;
          stuff_pending_d = 1'b0;
          stuff_active_d  = 1'b0;
          cur_arb_d       = 1'b0;
          cur_nocheck_d   = 1'b0;
        end
      end
      S_TX, S_DRAIN: begin
        if (go_error_frame || arb_det || err_det) begin
          state_d         = S_IDLE;
          tx_d            = 1'b1;
          stuff_pending_d = 1'b0;
          stuff_active_d  = 1'b0;
          cur_arb_d       = 1'b0;
          cur_nocheck_d   = 1'b0;
        end else begin
          if (drive_slot) begin
            tx_d           = tx_next;
            stuff_active_d = stuff_pending_q;
            cur_arb_d      = accept & in_arb;
            cur_nocheck_d  = accept & in_nocheck;
            if (stuff_pending_q) begin
              // The stuff bit opens the next run.
              run_cnt_d       = 3'd1;
              last_bit_d      = ~last_bit_q;
              stuff_pending_d = 1'b0;
            end else if (accept) begin
              last_bit_d = in_bit;
              if (in_stuff_en) begin
                run_cnt_d       = run_inc;
                stuff_pending_d = (run_inc == 3'(STUFF_LEN));
              end else begin
                run_cnt_d = 3'd0;
              end
              if (in_last) state_d = S_DRAIN;
            end
          end
          if (done_det) begin
            state_d        = S_IDLE;
            tx_d           = 1'b1;
            stuff_active_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      tx_q            <= 1'b1;
      run_cnt_q       <= 3'd0;
      last_bit_q      <= 1'b1;
      stuff_pending_q <= 1'b0;
      stuff_active_q  <= 1'b0;
      cur_arb_q       <= 1'b0;
      cur_nocheck_q   <= 1'b0;
      arb_lost_q      <= 1'b0;
      bit_error_q     <= 1'b0;
      tx_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_q            <= tx_d;
      run_cnt_q       <= run_cnt_d;
      last_bit_q      <= last_bit_d;
      stuff_pending_q <= stuff_pending_d;
      stuff_active_q  <= stuff_active_d;
      cur_arb_q       <= cur_arb_d;
      cur_nocheck_q   <= cur_nocheck_d;
      arb_lost_q      <= arb_lost_d;
      bit_error_q     <= bit_error_d;
      tx_done_q       <= tx_done_d;
    end
  end

  assign tx           = tx_q;
  assign transmitting = active;
  assign stuff_active = stuff_active_q;
  assign arb_lost     = arb_lost_q;
  assign bit_error    = bit_error_q;
  assign tx_done      = tx_done_q;

`ifdef CAN_TX_STATS_EN
  logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;
  logic             stuff_sent;
  logic             underrun_sent;

  // Only count slots that really reach the bus (an error aborts them).
  assign stuff_sent    = drive_slot & stuff_pending_q & ~arb_det & ~err_det;
  assign underrun_sent = underrun & ~arb_det & ~err_det;

  always_comb begin
    stuff_cnt_d    = stuff_cnt_q;
    err_cnt_d      = err_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    if (stuff_sent && (stuff_cnt_q != '1))          stuff_cnt_d    = stuff_cnt_q + 1'b1;
    if ((arb_det || err_det) && (err_cnt_q != '1))  err_cnt_d      = err_cnt_q + 1'b1;
    if (underrun_sent && (underrun_cnt_q != '1))    underrun_cnt_d = underrun_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stuff_cnt_q    <= '0;
      err_cnt_q      <= '0;
      underrun_cnt_q <= '0;
    end else begin
      stuff_cnt_q    <= stuff_cnt_d;
      err_cnt_q      <= err_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign stuff_cnt    = stuff_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
